// File: rtl/scoreboard_pkg.sv
// Shared types, 7-segment codes and elaboration helpers for the scoreboard.
package scoreboard_pkg;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  // Active-low segments, bit 6 = g ... bit 0 = a.
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0011000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  function automatic logic [6:0] seg7_decode(input bcd_digit_t digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

  // Binary to 4-digit packed BCD, used only on elaboration constants.
  function automatic logic [15:0] to_bcd(input int value);
    logic [15:0] result = '0;
    int          rest   = value;
    for (int i = 0; i < 4; i++) begin
      result[i*4 +: 4] = 4'(rest % 10);
      rest             = rest / 10;
    end
    return result;
  endfunction

endpackage

// File: rtl/scoreboard_bcd_counter.sv
// One player's saturating BCD score with a "this increment reaches the target" flag.
module bcd_score_counter
  import scoreboard_pkg::*;
#(
  parameter int                  DIGITS    = 2,
  parameter logic [DIGITS*4-1:0] TARGET    = '0,
  parameter bit                  TARGET_EN = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  inc,
  output logic [DIGITS*4-1:0]   score,
  output logic                  target_hit
);

  logic [DIGITS*4-1:0] score_q, score_d, score_inc;
  logic                carry;

  // NOTE: every variable gets its default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    score_inc = score_q;
    carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (score_q[i*4 +: 4] == 4'd9) begin
          score_inc[i*4 +: 4] = 4'd0;
        end else begin
          score_inc[i*4 +: 4] = score_q[i*4 +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    // Carry out of the top digit means all-9s: hold instead of wrapping.
    if (carry) score_inc = score_q;

    score_d = score_q;
    if (clear)    score_d = '0;
    else if (inc) score_d = score_inc;

    target_hit = TARGET_EN && inc && !clear && (score_inc == TARGET);
  end

  // NOTE: state registers use non-blocking assignments; reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (reset) score_q <= '0;
    else       score_q <= score_d;
  end

  assign score = score_q;

endmodule

// File: rtl/scoreboard.sv
// Multi-player BCD scoreboard: counts round wins, ends the match at WIN_TARGET, drives 7-segment codes.
module scoreboard
  import scoreboard_pkg::*;
#(
  parameter int   NUM_PLAYERS = 2,
  parameter int   DIGITS      = 2,
  parameter int   WIN_TARGET  = 10,
  localparam int  PW          = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            round_valid,
  input  logic [PW-1:0]                   round_winner,
  input  logic                            clear_scores,
  output logic                            round_ack,
  output logic [NUM_PLAYERS*DIGITS*4-1:0] score_bcd,
  output logic [NUM_PLAYERS*DIGITS*7-1:0] hex,
  output logic                            match_over,
  output logic [PW-1:0]                   match_winner
);

  localparam int          MAX_SCORE   = (10 ** DIGITS) - 1;
  localparam logic [15:0] TARGET_FULL = to_bcd(WIN_TARGET);

  if (NUM_PLAYERS < 2 || NUM_PLAYERS > 8 || DIGITS < 1 || DIGITS > 4 ||
      WIN_TARGET < 0 || WIN_TARGET > MAX_SCORE) begin : g_bad_params
    $error("scoreboard: parameter out of range");
  end

  state_e          state_q, state_d;
  logic [PW-1:0]   match_winner_q, match_winner_d;
  logic            round_ack_q, round_ack_d;
  logic            match_over_q, match_over_d;
  logic            counted;
  logic [NUM_PLAYERS-1:0] inc, hit;

  assign counted = round_valid && !clear_scores && (state_q == PLAY) &&
                   (int'(round_winner) < NUM_PLAYERS);

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    assign inc[p] = counted && (int'(round_winner) == p);

    bcd_score_counter #(
      .DIGITS    (DIGITS),
      .TARGET    (TARGET_FULL[DIGITS*4-1:0]),
      .TARGET_EN (WIN_TARGET != 0)
    ) u_counter (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear_scores),
      .inc        (inc[p]),
      .score      (score_bcd[p*DIGITS*4 +: DIGITS*4]),
      .target_hit (hit[p])
    );
  end

  for (genvar j = 0; j < NUM_PLAYERS*DIGITS; j++) begin : g_hex
    assign hex[j*7 +: 7] = seg7_decode(score_bcd[j*4 +: 4]);
  end

  always_comb begin
    state_d        = state_q;
    match_winner_d = match_winner_q;
    round_ack_d    = 1'b0;
    if (clear_scores) begin
      state_d        = PLAY;
      match_winner_d = '0;
    end else if (counted) begin
      round_ack_d = 1'b1;
      if (|hit) begin
        state_d        = OVER;
        match_winner_d = round_winner;
      end
    end
    match_over_d = (state_d == OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= PLAY;
      match_winner_q <= '0;
      round_ack_q    <= 1'b0;
      match_over_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      match_winner_q <= match_winner_d;
      round_ack_q    <= round_ack_d;
      match_over_q   <= match_over_d;
    end
  end

  assign round_ack    = round_ack_q;
  assign match_over   = match_over_q;
  assign match_winner = match_winner_q;

endmodule

// File: tb/tb_scoreboard.sv
// Scoreboard-style bench: two configurations driven with directed and random rounds against a score model.
module tb_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 2 players, 2 digits, target 10. Instance B: 3 players, 2 digits, no match end.
  logic        a_reset = 1'b1, a_clr = 1'b0, a_vld = 1'b0;
  logic [0:0]  a_win = '0;
  logic        a_ack, a_over;
  logic [15:0] a_score;
  logic [27:0] a_hex;
  logic [0:0]  a_mwin;

  logic        b_reset = 1'b1, b_clr = 1'b0, b_vld = 1'b0;
  logic [1:0]  b_win = '0;
  logic        b_ack, b_over;
  logic [23:0] b_score;
  logic [41:0] b_hex;
  logic [1:0]  b_mwin;

  scoreboard #(.NUM_PLAYERS(2), .DIGITS(2), .WIN_TARGET(10)) dut_a (
    .clk(clk), .reset(a_reset), .round_valid(a_vld), .round_winner(a_win),
    .clear_scores(a_clr), .round_ack(a_ack), .score_bcd(a_score), .hex(a_hex),
    .match_over(a_over), .match_winner(a_mwin)
  );

  scoreboard #(.NUM_PLAYERS(3), .DIGITS(2), .WIN_TARGET(0)) dut_b (
    .clk(clk), .reset(b_reset), .round_valid(b_vld), .round_winner(b_win),
    .clear_scores(b_clr), .round_ack(b_ack), .score_bcd(b_score), .hex(b_hex),
    .match_over(b_over), .match_winner(b_mwin)
  );

  typedef struct {
    int due;
    bit ack;
    int score [3];
    bit over;
    int winner;
  } snap_t;

  typedef struct {
    int player;
    int score;
  } ack_t;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

  int    checks = 0, failures = 0;
  int    cyc = 0;
  int    np [2] = '{2, 3};
  int    wt [2] = '{10, 0};
  int    m_score [2][3];
  bit    m_over [2];
  int    m_win [2];
  int    m_acks [2];
  bit    armed [2];
  int    b_acks = 0;
  snap_t sq0 [$], sq1 [$];
  ack_t  aq0 [$], aq1 [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs on DUT d (the other idles) and record what the model expects.
  task automatic step(input int d, input bit rst, input bit clr, input bit vld, input int win);
    snap_t s;
    bit    ack = 1'b0;
    @(negedge clk);
    a_reset = 1'b0; a_clr = 1'b0; a_vld = 1'b0; a_win = '0;
    b_reset = 1'b0; b_clr = 1'b0; b_vld = 1'b0; b_win = '0;
    if (d == 0) begin
      a_reset = rst; a_clr = clr; a_vld = vld; a_win = 1'(win);
    end else begin
      b_reset = rst; b_clr = clr; b_vld = vld; b_win = 2'(win);
    end

    if (rst || clr) begin
      for (int p = 0; p < 3; p++) m_score[d][p] = 0;
      m_over[d] = 1'b0;
      m_win[d]  = 0;
    end else if (vld && !m_over[d] && win < np[d]) begin
      ack_t a;
      ack = 1'b1;
      m_acks[d]++;
      if (m_score[d][win] < 99) m_score[d][win]++;
      a.player = win;
      a.score  = m_score[d][win];
      if (d == 0) aq0.push_back(a);
      else        aq1.push_back(a);
      if (wt[d] != 0 && m_score[d][win] == wt[d]) begin
        m_over[d] = 1'b1;
        m_win[d]  = win;
      end
    end

    s.due    = cyc + 1;
    s.ack    = ack;
    s.score  = m_score[d];
    s.over   = m_over[d];
    s.winner = m_win[d];
    if (d == 0) sq0.push_back(s);
    else        sq1.push_back(s);
  endtask

  task automatic mon(input int d);
    logic [23:0] sc;
    logic [41:0] hx;
    logic [3:0]  lo, hi;
    bit          ack, over, have;
    int          win, qsize, act_score;
    snap_t       s;
    ack_t        a;
    have = 1'b0;
    if (d == 0) begin
      sc = 24'(a_score); hx = 42'(a_hex); ack = a_ack; over = a_over; win = int'(a_mwin);
      if (sq0.size() > 0 && sq0[0].due == cyc) begin s = sq0.pop_front(); have = 1'b1; end
    end else begin
      sc = b_score; hx = b_hex; ack = b_ack; over = b_over; win = int'(b_mwin);
      if (sq1.size() > 0 && sq1[0].due == cyc) begin s = sq1.pop_front(); have = 1'b1; end
    end

    if (have) begin
      armed[d] = 1'b1;
      for (int p = 0; p < np[d]; p++) begin
        lo = sc[p*8 +: 4];
        hi = sc[p*8+4 +: 4];
        check($sformatf("dut%0d_p%0d_digit_range", d, p), int'(lo <= 4'd9 && hi <= 4'd9), 1);
        check($sformatf("dut%0d_p%0d_score", d, p), int'(hi) * 10 + int'(lo), s.score[p]);
        check($sformatf("dut%0d_p%0d_hex_lo", d, p), int'(hx[(p*2)*7 +: 7]),
              int'(seg_tab[s.score[p] % 10]));
        check($sformatf("dut%0d_p%0d_hex_hi", d, p), int'(hx[(p*2+1)*7 +: 7]),
              int'(seg_tab[s.score[p] / 10]));
      end
      check($sformatf("dut%0d_round_ack", d), int'(ack), int'(s.ack));
      check($sformatf("dut%0d_match_over", d), int'(over), int'(s.over));
      check($sformatf("dut%0d_match_winner", d), win, s.winner);
    end

    if (armed[d] && ack) begin
      qsize = (d == 0) ? aq0.size() : aq1.size();
      check($sformatf("dut%0d_ack_expected", d), int'(qsize > 0), 1);
      if (qsize > 0) begin
        a = (d == 0) ? aq0.pop_front() : aq1.pop_front();
        act_score = int'(sc[a.player*8+4 +: 4]) * 10 + int'(sc[a.player*8 +: 4]);
        check($sformatf("dut%0d_ack_p%0d_score", d, a.player), act_score, a.score);
      end
      if (d == 1) b_acks++;
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_base, r;
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);

    // Ten wins for player 0 end the match at 10.
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);                       // ignored while OVER
    step(0, 0, 1, 0, 0);                       // clear back to PLAY
    step(0, 0, 1, 1, 1);                       // clear beats a same-cycle round
    repeat (7) step(0, 0, 0, 1, 0);
    step(0, 1, 1, 0, 0);                       // reset plus clear at 07
    repeat (9) step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);                       // 09 -> 10, also reaches the target
    step(0, 1, 0, 1, 0);                       // reset while OVER with a round pending
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 99));
      step(0, r < 2, r >= 2 && r < 7, $urandom_range(0, 99) < 60, int'($urandom_range(0, 1)));
    end

    // Instance B: saturation at 99 with match end disabled.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    #1 b_base = b_acks;
    repeat (100) step(1, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    #1 check("dut1_acks_for_100_wins", b_acks - b_base, 100);
    step(1, 0, 0, 1, 3);                       // out-of-range winner
    step(1, 0, 0, 1, 2);
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 99));
      step(1, r < 2, r >= 2 && r < 7, $urandom_range(0, 99) < 60, int'($urandom_range(0, 3)));
    end

    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    #1;
    check("dut0_ack_queue_drained", aq0.size(), 0);
    check("dut1_ack_queue_drained", aq1.size(), 0);
    check("dut0_snap_queue_drained", sq0.size(), 0);
    check("dut1_total_acks", b_acks, m_acks[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scoreboard.md
SCOREBOARD -- requirements
Module: scoreboard

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2: number of player score channels (2..8).
REQ-002 SHALL have parameter DIGITS, default 2: BCD digits per player score (1..4).
REQ-003 SHALL have parameter WIN_TARGET, default 10: score that ends a match; 0 disables match end (legal range 0..10^DIGITS-1, elaboration error otherwise).
REQ-004 SHALL have port clk, input, 1: single clock; one clock, all state on rising edge.
REQ-005 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-006 SHALL have port round_valid, input, 1: one-cycle pulse, a round has ended.
REQ-007 SHALL have port round_winner, input, PW = max(1, clog2(NUM_PLAYERS)): winning player index, sampled with round_valid.
REQ-008 SHALL have port clear_scores, input, 1: soft clear of scores and match state.
REQ-009 SHALL have port round_ack, output, 1: one-cycle pulse, round was counted.
REQ-010 SHALL have port score_bcd, output, NUM_PLAYERS*DIGITS*4: packed BCD scores; player 0 in the LSBs, least-significant digit lowest.
REQ-011 SHALL have port hex, output, NUM_PLAYERS*DIGITS*7: active-low 7-segment codes, same packing as score_bcd.
REQ-012 SHALL have port match_over, output, 1: high while a match is decided.
REQ-013 SHALL have port match_winner, output, PW: index of the match winner, valid while match_over.

Function
REQ-014 SHALL implement a two-state FSM: PLAY and OVER.
REQ-015 In PLAY, round_valid=1 with round_winner<NUM_PLAYERS SHALL add 1 to that player's BCD score at the same edge; score_bcd updates one cycle after the pulse.
REQ-016 round_ack SHALL assert for exactly one cycle in the cycle after each counted round; uncounted rounds produce no ack.
REQ-017 round_valid with round_winner>=NUM_PLAYERS SHALL be ignored: no score change, no ack.
REQ-018 BCD increment SHALL carry digit by digit (9->0 with carry); every digit SHALL always hold 0..9.
REQ-019 A score at all-9s (e.g. 99 for DIGITS=2) SHALL saturate: a further win leaves it unchanged but still acks.
REQ-020 If WIN_TARGET!=0 and a counted win makes that player's score equal WIN_TARGET, the FSM SHALL go to OVER at the same edge, with match_winner latched to that player.
REQ-021 In OVER, round_valid SHALL be ignored (no score change, no ack); scores and match_winner SHALL hold.
REQ-022 clear_scores=1 in either state SHALL zero all scores, clear match_over and match_winner, and enter PLAY at the next edge.
REQ-023 clear_scores and round_valid in the same cycle: clear SHALL win; the round is dropped with no ack.
REQ-024 match_over SHALL be a registered decode of state OVER.
REQ-025 hex SHALL be a combinational decode of score_bcd using the team's active-low table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000; non-BCD values SHALL decode to 0111111.
REQ-026 WIN_TARGET SHALL be compared as a BCD constant computed at elaboration; no binary shadow counters.

Reset
REQ-027 reset=1 SHALL, at the next edge, set all scores to 0, state to PLAY, match_over to 0, match_winner to 0 and round_ack to 0; hex then reads 1000000 on every digit.
REQ-028 reset SHALL override clear_scores and round_valid in the same cycle, including mid-match and in OVER.

Structure
REQ-029 Package scoreboard_pkg SHALL hold the FSM state typedef, the 7-segment code constants (including the blank/dash code) and the BCD digit typedef.
REQ-030 One sub-module, bcd_score_counter (DIGITS-parametrised, with synchronous clear, increment enable, saturation and an equals-target flag), SHALL be instantiated NUM_PLAYERS times; the 7-segment decode SHALL be a package function.

Verification
REQ-031 Reset, then 10 pulses with winner=0 (defaults) -> score0 reads 01..10, ack after each; after the 10th, match_over=1, match_winner=0, hex for player 0 = 1111001,1000000.
REQ-032 In OVER, pulse round_valid winner=1 -> no ack, score1 unchanged; then clear_scores -> all scores 00, match_over=0 the next cycle.
REQ-033 WIN_TARGET=0, DIGITS=2, 100 wins for player 1 -> score stops at 99, 100 acks, match_over never asserts.
REQ-034 NUM_PLAYERS=3, round_winner=3 -> ignored, no ack; round_winner=2 -> score2 increments.
REQ-035 clear_scores and round_valid in the same cycle -> scores 00, no ack; reset and clear_scores in the same cycle with score 07 -> scores 00, PLAY.
REQ-036 Score 09 plus one win -> 10, low digit carries 9->0; checker confirms no digit ever exceeds 9.
